// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned MAX_WIDTH = 64;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Subtraction runs as a + ~b + ~borrow, so b is complemented at acceptance.
    function automatic logic [MAX_WIDTH-1:0] sub_operand(input logic [MAX_WIDTH-1:0] op,
                                                         input logic            sub);
        return sub ? ~op : op;
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// DIGIT-wide combinational ripple of full-adder cells.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[DIGIT];
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits per clock, carry held between cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(N);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end
    if (WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH exceeds MAX_WIDTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [WIDTH-1:0] b_x, sum_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, sub_q, sub_d;
    logic             msb_a_q, msb_a_d, msb_b_q, msb_b_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [DIGIT-1:0] dsum;
    logic             dcout;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (dsum),
        .cout (dcout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            msb_a_q <= 1'b0;
            msb_b_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            msb_a_q <= msb_a_d;
            msb_b_q <= msb_b_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        sub_d     = sub_q;
        msb_a_d   = msb_a_q;
        msb_b_d   = msb_b_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        b_x       = WIDTH'(sub_operand(MAX_WIDTH'(b), sub));
        // New digit enters at the top; also valid when DIGIT == WIDTH (shift by zero).
        sum_shift = (sum_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_x;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    sub_d   = sub;
                    msb_a_d = a[WIDTH-1];
                    msb_b_d = b_x[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_shift;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dcout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cout_d  = dcout ^ sub_q;
                    ovf_d   = (msb_a_q == msb_b_q) && (dsum[DIGIT-1] != msb_a_q);
                    zero_d  = (sum_shift == '0);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
